// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard and stall controller at the ID stage of the five-stage pipeline.
// Detects a dependency between the ID instruction's sources and an EX-stage load.
// When it finds one, it holds the PC for LOAD_LAT cycles.
// It also provides a sticky halt state, a synchronous flush and a saturating stall counter.
module load_use_stall_ctrl #(
    parameter int              REG_AW    = 5,
    parameter int              OP_W      = 7,
    parameter int              LOAD_LAT  = 1,
    parameter int              CNT_W     = 3,
    parameter logic [OP_W-1:0] HALT_OP   = 7'h7F,
    parameter logic [OP_W-1:0] LOAD_OP   = 7'h03,
    parameter bit              IGNORE_X0 = 1'b1,
    parameter int              PERF_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in,
    input  logic              clear,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   preop,
    input  logic [REG_AW-1:0] prerd,
    output logic              Mwk,
    output logic              PCdelay,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    // A single-cycle stall never enters STALL; the bubble behind the load clears the hazard by itself.
    localparam bit MULTI_CYCLE = (LOAD_LAT > 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              mwk_nx, pcdelay_nx, halted_nx;
    logic              use_rs1, use_rs2;
    logic              hz, halt_req, perf_inc;

    // Work out which source registers the ID opcode actually reads.
    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (id_op)
            7'b0110011, 7'b1100011, 7'b0100011: use_rs2 = 1'b1;
            7'b0110111, 7'b0010111, 7'b1101111: use_rs1 = 1'b0;
            default: ;
        endcase
    end

    assign hz = ex_valid && (preop == LOAD_OP)
             && !(IGNORE_X0 && (prerd == '0))
             && ((use_rs1 && (rs1 == prerd)) || (use_rs2 && (rs2 == prerd)));

    assign halt_req = ex_valid && (preop == HALT_OP);

    // The down-counter holds the number of stall cycles still to run, counting the current one.
    // It counts down to 1, and the held instruction issues on that edge.
    // Register the state, the down-counter, the outputs and the saturating stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            cnt       <= '0;
            Mwk       <= 1'b0;
            PCdelay   <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            Mwk     <= mwk_nx;
            PCdelay <= pcdelay_nx;
            halted  <= halted_nx;
            if (perf_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Choose the next state and counter value; priority is clear > halt > hazard > issue.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (clear) begin
                    cnt_nx = '0;
                end else if (in) begin
                    if (halt_req) begin
                        state_nx = HALT;
                    end else if (hz) begin
                        if (MULTI_CYCLE) begin
                            state_nx = STALL;
                            cnt_nx   = CNT_W'(LOAD_LAT);
                        end else begin
                            cnt_nx = '0;
                        end
                    end
                end
            end
            STALL: begin
                if (!clear && (cnt > CNT_W'(1))) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            HALT: begin
                cnt_nx = '0;
                if (clear)
                    state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Decide the values the outputs take after this edge; halt cycles never count as load-use stalls.
    always_comb begin
        mwk_nx     = 1'b0;
        pcdelay_nx = 1'b0;
        halted_nx  = 1'b0;
        case (state)
            RUN: begin
                if (!clear && in) begin
                    if (halt_req) begin
                        pcdelay_nx = 1'b1;
                        halted_nx  = 1'b1;
                    end else if (hz) begin
                        pcdelay_nx = 1'b1;
                    end else begin
                        mwk_nx = 1'b1;
                    end
                end
            end
            STALL: begin
                if (!clear) begin
                    if (cnt > CNT_W'(1))
                        pcdelay_nx = 1'b1;
                    else
                        mwk_nx = 1'b1;
                end
            end
            HALT: begin
                if (!clear) begin
                    pcdelay_nx = 1'b1;
                    halted_nx  = 1'b1;
                end
            end
            default: ;
        endcase
        perf_inc = pcdelay_nx && !halted_nx;
    end

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench for load_use_stall_ctrl.
// Three instances share one set of input stimulus:
// LOAD_LAT=1 with a 16-bit counter, LOAD_LAT=3 with a 16-bit counter, and LOAD_LAT=1 with a 2-bit counter.
module tb_load_use_stall_ctrl;

    localparam int ND = 3;

    logic       clk, rst, id_in, clear, ex_valid;
    logic [6:0] id_op, preop;
    logic [4:0] rs1, rs2, prerd;

    logic        mwk_a, pcd_a, hlt_a, mwk_b, pcd_b, hlt_b, mwk_c, pcd_c, hlt_c;
    logic [15:0] sc_a, sc_b;
    logic [1:0]  sc_c;

    logic        act_mwk [ND];
    logic        act_pcd [ND];
    logic        act_hlt [ND];
    logic [15:0] act_cnt [ND];

    int vectors = 0;
    int miscompares = 0;

    // Behavioural reference: pending-issue flag plus number of extra stall cycles left.
    int lat  [ND] = '{1, 3, 1};
    int cmax [ND] = '{65535, 65535, 3};
    bit m_pend [ND];
    int m_left [ND];
    bit m_halt [ND];
    bit e_mwk [ND];
    bit e_pcd [ND];
    bit e_hlt [ND];
    int e_cnt [ND];

    load_use_stall_ctrl #(.LOAD_LAT(1), .PERF_W(16)) dut_a (
        .CLK(clk), .RST(rst), .in(id_in), .clear(clear), .id_op(id_op), .rs1(rs1), .rs2(rs2),
        .ex_valid(ex_valid), .preop(preop), .prerd(prerd),
        .Mwk(mwk_a), .PCdelay(pcd_a), .halted(hlt_a), .stall_cnt(sc_a));

    load_use_stall_ctrl #(.LOAD_LAT(3), .PERF_W(16)) dut_b (
        .CLK(clk), .RST(rst), .in(id_in), .clear(clear), .id_op(id_op), .rs1(rs1), .rs2(rs2),
        .ex_valid(ex_valid), .preop(preop), .prerd(prerd),
        .Mwk(mwk_b), .PCdelay(pcd_b), .halted(hlt_b), .stall_cnt(sc_b));

    load_use_stall_ctrl #(.LOAD_LAT(1), .PERF_W(2)) dut_c (
        .CLK(clk), .RST(rst), .in(id_in), .clear(clear), .id_op(id_op), .rs1(rs1), .rs2(rs2),
        .ex_valid(ex_valid), .preop(preop), .prerd(prerd),
        .Mwk(mwk_c), .PCdelay(pcd_c), .halted(hlt_c), .stall_cnt(sc_c));

    assign act_mwk[0] = mwk_a;
    assign act_mwk[1] = mwk_b;
    assign act_mwk[2] = mwk_c;
    assign act_pcd[0] = pcd_a;
    assign act_pcd[1] = pcd_b;
    assign act_pcd[2] = pcd_c;
    assign act_hlt[0] = hlt_a;
    assign act_hlt[1] = hlt_b;
    assign act_hlt[2] = hlt_c;
    assign act_cnt[0] = sc_a;
    assign act_cnt[1] = sc_b;
    assign act_cnt[2] = {14'd0, sc_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hazard rule written directly from the opcode source-usage table.
    function automatic bit ref_hazard();
        bit r2, r1;
        r2 = (id_op == 7'h33) || (id_op == 7'h63) || (id_op == 7'h23);
        r1 = !((id_op == 7'h37) || (id_op == 7'h17) || (id_op == 7'h6F));
        return ex_valid && (preop == 7'h03) && (prerd != 0)
            && ((r1 && rs1 == prerd) || (r2 && rs2 == prerd));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_pend[d] = 0; m_left[d] = 0; m_halt[d] = 0;
            e_mwk[d] = 0; e_pcd[d] = 0; e_hlt[d] = 0; e_cnt[d] = 0;
        end
    endtask

    task automatic model_step();
        bit h;
        h = ref_hazard();
        for (int d = 0; d < ND; d++) begin
            e_mwk[d] = 0; e_pcd[d] = 0; e_hlt[d] = 0;
            if (clear) begin
                m_pend[d] = 0; m_left[d] = 0; m_halt[d] = 0;
            end else if (m_halt[d]) begin
                e_pcd[d] = 1; e_hlt[d] = 1;
            end else if (m_pend[d]) begin
                if (m_left[d] > 0) begin
                    m_left[d]--; e_pcd[d] = 1;
                    if (e_cnt[d] < cmax[d]) e_cnt[d]++;
                end else begin
                    m_pend[d] = 0; e_mwk[d] = 1;
                end
            end else if (!id_in) begin
            end else if (ex_valid && preop == 7'h7F) begin
                m_halt[d] = 1; e_pcd[d] = 1; e_hlt[d] = 1;
            end else if (h) begin
                e_pcd[d] = 1;
                if (e_cnt[d] < cmax[d]) e_cnt[d]++;
                if (lat[d] > 1) begin
                    m_pend[d] = 1; m_left[d] = lat[d] - 1;
                end
            end else begin
                e_mwk[d] = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input bit c, input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b, input bit ev, input logic [6:0] pop, input logic [4:0] rd);
        id_in = v; clear = c; id_op = op; rs1 = a; rs2 = b;
        ex_valid = ev; preop = pop; prerd = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 7'h13, 0, 0, 0, 7'h13, 0);
        #3;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 7'h13, 0, 0, 0, 7'h13, 0);
        model_reset();
        #3;
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if ({act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d]} !== 19'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_state dut%0d got mwk=%b pcd=%b hlt=%b cnt=%0d need all 0",
                         d, act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        // load x5 in EX, ID reads x5, then one stall cycle so the LAT=3 instance is mid-stall
        drive(1, 0, 7'h33, 5, 7, 1, 7'h03, 5);
        cycle();
        drive(1, 0, 7'h33, 5, 7, 0, 7'h13, 0);
        cycle();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if ({act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d]} !== 19'd0) begin
                miscompares++;
                $display("[TB] FAIL async_reset dut%0d got mwk=%b pcd=%b cnt=%0d need all 0",
                         d, act_mwk[d], act_pcd[d], act_cnt[d]);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 7'h13, 1, 0, 0, 7'h13, 0);
        cycle();
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if ({act_mwk[d], act_pcd[d]} !== {e_mwk[d], e_pcd[d]} || e_mwk[d] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL run_after_reset dut%0d got mwk=%b pcd=%b need mwk=1 pcd=0",
                         d, act_mwk[d], act_pcd[d]);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int s = 0; s < 6; s++) begin
            if (s == 0) drive(1, 0, 7'h33, 5, 7, 1, 7'h03, 5);
            else        drive(1, 0, 7'h33, 5, 7, 0, 7'h13, 0);
            cycle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if ({act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d]} !== {e_mwk[d], e_pcd[d], e_hlt[d], 16'(e_cnt[d])}) begin
                    miscompares++;
                    $display("[TB] FAIL load_use s%0d dut%0d got mwk=%b pcd=%b cnt=%0d need mwk=%b pcd=%b cnt=%0d",
                             s, d, act_mwk[d], act_pcd[d], act_cnt[d], e_mwk[d], e_pcd[d], e_cnt[d]);
                end
            end
        end
    endtask

    task automatic test_store_rs2();
        do_reset();
        for (int s = 0; s < 6; s++) begin
            if (s == 0) drive(1, 0, 7'h23, 1, 5, 1, 7'h03, 5);
            else        drive(1, 0, 7'h23, 1, 5, 0, 7'h13, 0);
            cycle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if ({act_mwk[d], act_pcd[d], act_cnt[d]} !== {e_mwk[d], e_pcd[d], 16'(e_cnt[d])}) begin
                    miscompares++;
                    $display("[TB] FAIL store_rs2 s%0d dut%0d got mwk=%b pcd=%b cnt=%0d need mwk=%b pcd=%b cnt=%0d",
                             s, d, act_mwk[d], act_pcd[d], act_cnt[d], e_mwk[d], e_pcd[d], e_cnt[d]);
                end
            end
        end
        vectors++;
        if (sc_b !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL lat3_stall_count got %0d need 3", sc_b);
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            if (s == 0) drive(1, 0, 7'h33, 0, 0, 1, 7'h03, 0);
            else        drive(1, 0, 7'h37, 5, 5, 1, 7'h03, 5);
            cycle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if ({act_mwk[d], act_pcd[d]} !== {e_mwk[d], e_pcd[d]} || act_mwk[d] !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL no_stall s%0d dut%0d got mwk=%b pcd=%b need mwk=1 pcd=0",
                             s, d, act_mwk[d], act_pcd[d]);
                end
            end
        end
    endtask

    task automatic test_halt_clear();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            case (s)
                0:       drive(1, 0, 7'h13, 1, 2, 1, 7'h7F, 0);
                1, 2:    drive(1, 0, 7'h33, 5, 7, 1, 7'h03, 5);
                3:       drive(0, 1, 7'h13, 0, 0, 0, 7'h13, 0);
                4:       drive(1, 0, 7'h33, 5, 7, 1, 7'h03, 5);
                5:       drive(1, 1, 7'h33, 5, 7, 0, 7'h13, 0);
                default: drive(1, 0, 7'h13, 1, 1, 0, 7'h13, 0);
            endcase
            cycle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if ({act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d]} !== {e_mwk[d], e_pcd[d], e_hlt[d], 16'(e_cnt[d])}) begin
                    miscompares++;
                    $display("[TB] FAIL halt_clear s%0d dut%0d got mwk=%b pcd=%b hlt=%b cnt=%0d need mwk=%b pcd=%b hlt=%b cnt=%0d",
                             s, d, act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d], e_mwk[d], e_pcd[d], e_hlt[d], e_cnt[d]);
                end
            end
        end
    endtask

    task automatic test_perf_saturate();
        do_reset();
        for (int s = 0; s < 10; s++) begin
            if (s % 2 == 0) drive(1, 0, 7'h13, 4, 0, 1, 7'h03, 4);
            else            drive(1, 0, 7'h13, 4, 0, 0, 7'h13, 0);
            cycle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if ({act_mwk[d], act_pcd[d], act_cnt[d]} !== {e_mwk[d], e_pcd[d], 16'(e_cnt[d])}) begin
                    miscompares++;
                    $display("[TB] FAIL perf_sat s%0d dut%0d got mwk=%b pcd=%b cnt=%0d need mwk=%b pcd=%b cnt=%0d",
                             s, d, act_mwk[d], act_pcd[d], act_cnt[d], e_mwk[d], e_pcd[d], e_cnt[d]);
                end
            end
        end
        vectors++;
        if (sc_c !== 2'd3 || sc_a !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL perf_sat_final got c=%0d a=%0d need c=3 a=5", sc_c, sc_a);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [8] = '{7'h33, 7'h63, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h03, 7'h13};
        logic [6:0] pop;
        int r;
        do_reset();
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 19);
            pop = (r < 11) ? 7'h03 : (r == 11) ? 7'h7F : ops[$urandom_range(0, 7)];
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 11) == 0),
                  ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), pop, 5'($urandom_range(0, 3)));
            cycle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if ({act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d]} !== {e_mwk[d], e_pcd[d], e_hlt[d], 16'(e_cnt[d])}) begin
                    miscompares++;
                    $display("[TB] FAIL random s%0d dut%0d got mwk=%b pcd=%b hlt=%b cnt=%0d need mwk=%b pcd=%b hlt=%b cnt=%0d",
                             s, d, act_mwk[d], act_pcd[d], act_hlt[d], act_cnt[d], e_mwk[d], e_pcd[d], e_hlt[d], e_cnt[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store_rs2();
        test_no_stall();
        test_halt_clear();
        test_perf_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
